if_fetch_unit: RTL and testbench



---
 rtl/if_fetch_unit_pkg.sv | 28 ++
 rtl/if_fetch_unit_if.sv | 45 ++++
 rtl/if_fetch_unit_fifo.sv | 76 +++++++
 rtl/if_fetch_unit.sv | 207 ++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// ctrl_encode_def
//   Shared encodings for the instruction fetch stage: fetch FSM states,
//   default reset PC, sequential PC increment and the buffered-entry layout.
// ----------------------------------------------------------------------------
package ctrl_encode_def;

    typedef enum logic [1:0] {
        IF_IDLE = 2'd0,
        IF_REQ  = 2'd1,
        IF_WAIT = 2'd2
    } if_state_e;

    localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] IF_PC_INC   = 32'd4;

    // One instruction buffer entry: the fetched word together with its PC.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } if_entry_t;

    // Sequential successor; 32-bit arithmetic wraps 32'hFFFF_FFFC -> 0.
    function automatic logic [31:0] if_pc_next(input logic [31:0] pc);
        return pc + IF_PC_INC;
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_if
//   Bundles the instruction-memory request channel (req/addr/gnt/rvalid/rdata)
//   and the decode-side instruction channel (valid/inst/pc/ready).
//   master : the fetch unit
//   slave  : instruction memory + decode (the environment)
// ----------------------------------------------------------------------------
interface if_fetch_unit_if;

    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;

    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output inst_valid_o,
        output inst_o,
        output inst_pc_o,
        input  inst_ready_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  inst_valid_o,
        input  inst_o,
        input  inst_pc_o,
        output inst_ready_i
    );

endinterface

// File: rtl/if_fetch_unit_fifo.sv
// ----------------------------------------------------------------------------
// if_fifo
//   Synchronous FIFO of {pc, inst} entries for the fetch stage.
//   Ports:
//     clk, rstn   clock / asynchronous active-low reset
//     push_i      write wdata_i (ignored when full unless popping)
//     pop_i       drop head (ignored when empty)
//     flush_i     empty the FIFO; overrides push and pop in the same cycle
//     wdata_i     entry to write
//     rdata_o     entry at head
//     count_o     number of valid entries
//   DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ----------------------------------------------------------------------------
module if_fifo
    import ctrl_encode_def::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic                      flush_i,
    input  if_entry_t                 wdata_i,
    output if_entry_t                 rdata_o,
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    if_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;

    logic full;
    logic do_push;
    logic do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= wdata_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign rdata_o = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Fetch stage owning the architectural fetch PC. Issues one instruction
//   memory request at a time over req/gnt/rvalid, buffers returned words with
//   their PCs in if_fifo and presents them to decode over valid/ready.
//   Sequential fetch at PC+4; a redirect loads a new PC, flushes the buffer
//   and squashes any in-flight response.
//   Ports:
//     clk, rstn        clock / asynchronous active-low reset
//     redirect_i       taken branch/jump, load redirect_pc_i
//     redirect_pc_i    redirect target
//     fetch_err_o      sticky misaligned-redirect flag (IF_MISALIGN_CHK_EN only)
//     bus (master)     imem_req_o/imem_addr_o/imem_gnt_i/imem_rvalid_i/
//                      imem_rdata_i and inst_valid_o/inst_o/inst_pc_o/
//                      inst_ready_i
//   Build option:
//     IF_MISALIGN_CHK_EN  misaligned redirect target raises fetch_err_o and
//                         parks the fetcher; otherwise targets are aligned
//                         down to a word boundary.
// ----------------------------------------------------------------------------
module if_fetch_unit
    import ctrl_encode_def::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect_i,
    input  logic [31:0]       redirect_pc_i,
`ifdef IF_MISALIGN_CHK_EN
    output logic              fetch_err_o,
`endif
    if_fetch_unit_if.master   bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    if_state_e   state_q,    state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q,   req_pc_d;
    logic        discard_q,  discard_d;
    // Set when a redirect hit REQ before the grant: the address on the bus
    // is the old PC (held in req_pc_q) and its grant must not advance fetch_pc.
    logic        stale_q,    stale_d;

    logic [31:0] tgt_pc;
    logic        tgt_bad;
    logic        parked;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_flush;
    if_entry_t        fifo_wdata;
    if_entry_t        fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] cnt_next;
    logic             space;

`ifdef IF_MISALIGN_CHK_EN
    logic err_q;

    assign tgt_pc  = redirect_pc_i;
    assign tgt_bad = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign parked  = err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (tgt_bad) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err_o = err_q;
`else
    assign tgt_pc  = redirect_pc_i & ~32'h0000_0003;
    assign tgt_bad = 1'b0;
    assign parked  = 1'b0;
`endif

    // ---------------------------------------------------------------- buffer
    assign fifo_flush = redirect_i;
    assign fifo_pop   = bus.inst_valid_o && bus.inst_ready_i;
    assign fifo_push  = (state_q == IF_WAIT) && bus.imem_rvalid_i &&
                        !discard_q && !redirect_i;
    assign fifo_wdata = '{pc: req_pc_q, inst: bus.imem_rdata_i};

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    // Occupancy after this cycle's push/pop/flush; a new request is only
    // launched when its response is guaranteed a slot.
    always_comb begin
        cnt_next = fifo_count;
        if (redirect_i) begin
            cnt_next = '0;
        end else begin
            if (fifo_push) cnt_next = cnt_next + CNT_W'(1);
            if (fifo_pop)  cnt_next = cnt_next - CNT_W'(1);
        end
    end

    assign space = (cnt_next < CNT_W'(FIFO_DEPTH));

    // -------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IF_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            stale_q    <= stale_d;
        end
    end

    // ------------------------------------------------------------ next state
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        discard_d  = discard_q;
        stale_d    = stale_q;

        unique case (state_q)
            IF_IDLE: begin
                if (space && !parked) state_d = IF_REQ;
            end
            IF_REQ: begin
                if (bus.imem_gnt_i) begin
                    state_d = IF_WAIT;
                    if (stale_q) begin
                        discard_d = 1'b1;
                        stale_d   = 1'b0;
                    end else begin
                        req_pc_d   = fetch_pc_q;
                        fetch_pc_d = if_pc_next(fetch_pc_q);
                    end
                end
            end
            IF_WAIT: begin
                if (bus.imem_rvalid_i) begin
                    discard_d = 1'b0;
                    state_d   = space ? IF_REQ : IF_IDLE;
                end
            end
            default: state_d = IF_IDLE;
        endcase

        // Redirect overrides the PC update above. Only the first redirect in
        // REQ captures the bus address; later ones just retarget fetch_pc.
        if (redirect_i) begin
            fetch_pc_d = tgt_pc;
            case (state_q)
                IF_REQ: begin
                    if (bus.imem_gnt_i) begin
                        discard_d = 1'b1;
                    end else if (!stale_q) begin
                        stale_d  = 1'b1;
                        req_pc_d = fetch_pc_q;
                    end
                end
                IF_WAIT: begin
                    if (!bus.imem_rvalid_i) discard_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (tgt_bad) begin
            state_d   = IF_IDLE;
            discard_d = 1'b0;
            stale_d   = 1'b0;
        end
    end

    // ---------------------------------------------------------------- output
    always_comb begin
        bus.imem_req_o  = 1'b0;
        bus.imem_addr_o = '0;
        if (state_q == IF_REQ) begin
            bus.imem_req_o  = 1'b1;
            bus.imem_addr_o = stale_q ? req_pc_q : fetch_pc_q;
        end
    end

    assign bus.inst_valid_o = (fifo_count != '0);
    assign bus.inst_o       = fifo_head.inst;
    assign bus.inst_pc_o    = fifo_head.pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Directed bench for if_fetch_unit. A small instruction-memory model grants
//   according to gnt_en and returns rvalid lat cycles after each grant with
//   data = addr ^ MAGIC. Granted addresses and popped (pc, inst) pairs are
//   logged and compared against hand-derived sequences.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;
    import ctrl_encode_def::*;

    localparam logic [31:0] MAGIC = 32'hA5A5_F00F;

    logic        clk           = 1'b0;
    logic        rstn          = 1'b1;
    logic        redirect_i    = 1'b0;
    logic [31:0] redirect_pc_i = '0;
`ifdef IF_MISALIGN_CHK_EN
    logic        fetch_err_o;
`endif

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
`ifdef IF_MISALIGN_CHK_EN
        .fetch_err_o   (fetch_err_o),
`endif
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    bit          gnt_en    = 1'b1;
    int unsigned lat       = 1;
    bit          pend      = 1'b0;
    int unsigned pend_wait = 0;
    logic [31:0] pend_addr = '0;

    logic [31:0] grants [$];
    logic [31:0] pops   [$];
    logic [31:0] insts  [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] qat(input logic [31:0] q [$], input int unsigned i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // One clock: log a pop that the coming edge will perform, then after the
    // edge drive the memory model for the following edge.
    task automatic tick();
        if (bus.inst_valid_o && bus.inst_ready_i && !redirect_i && rstn) begin
            pops.push_back(bus.inst_pc_o);
            insts.push_back(bus.inst_o);
        end
        @(posedge clk);
        #1;
        bus.imem_rvalid_i = 1'b0;
        if (pend) begin
            if (pend_wait == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i  = pend_addr ^ MAGIC;
                pend              = 1'b0;
            end else begin
                pend_wait--;
            end
        end
        bus.imem_gnt_i = gnt_en;
        if (bus.imem_req_o && gnt_en && rstn) begin
            pend      = 1'b1;
            pend_wait = lat - 1;
            pend_addr = bus.imem_addr_o;
            grants.push_back(bus.imem_addr_o);
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic wait_grant(input logic [31:0] a);
        int unsigned n = 0;
        while (!(grants.size() != 0 && grants[grants.size()-1] == a) && n < 60) begin
            tick();
            n++;
        end
        check("wait_grant", 32'(grants.size() != 0 && grants[grants.size()-1] == a), 32'd1);
    endtask

    task automatic do_reset(input bit chk);
        rstn       = 1'b0;
        redirect_i = 1'b0;
        pend       = 1'b0;
        gnt_en     = 1'b1;
        lat        = 1;
        bus.inst_ready_i = 1'b1;
        tick();
        tick();
        if (chk) begin
            check("rst_req",   32'(bus.imem_req_o),   32'd0);
            check("rst_addr",  bus.imem_addr_o,       32'd0);
            check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
            check("rst_inst",  bus.inst_o,            32'd0);
            check("rst_pc",    bus.inst_pc_o,         32'd0);
        end
        rstn = 1'b1;
        grants.delete();
        pops.delete();
        insts.delete();
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        tick();
        redirect_i    = 1'b0;
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.inst_ready_i  = 1'b1;
        #2;

        // Sequential fetch from reset, first valid two cycles after first req
        do_reset(1'b1);
        tick();
        check("t1_req",   32'(bus.imem_req_o), 32'd1);
        check("t1_addr",  bus.imem_addr_o,     32'h0);
        tick();
        check("t1_valid_early", 32'(bus.inst_valid_o), 32'd0);
        tick();
        check("t1_valid", 32'(bus.inst_valid_o), 32'd1);
        check("t1_pc",    bus.inst_pc_o,         32'h0);
        check("t1_inst",  bus.inst_o,            MAGIC);
        run(6);
        for (int unsigned i = 0; i < 3; i++) begin
            check("t1_pop_pc",   qat(pops, i),  32'(4 * i));
            check("t1_pop_inst", qat(insts, i), 32'(4 * i) ^ MAGIC);
        end

        // Backpressure: buffer fills, requests stop, resume at 8
        do_reset(1'b0);
        bus.inst_ready_i = 1'b0;
        run(12);
        check("t2_req_stop", 32'(bus.imem_req_o),   32'd0);
        check("t2_valid",    32'(bus.inst_valid_o), 32'd1);
        check("t2_head_pc",  bus.inst_pc_o,         32'h0);
        check("t2_ngrants",  32'(grants.size()),    32'd2);
        bus.inst_ready_i = 1'b1;
        run(10);
        check("t2_resume_addr", qat(grants, 2), 32'h8);
        for (int unsigned i = 0; i < 4; i++) begin
            check("t2_pop_pc", qat(pops, i), 32'(4 * i));
        end

        // Redirect while waiting for the 0x10 response (slow memory)
        do_reset(1'b0);
        lat = 3;
        wait_grant(32'h10);
        tick();
        redirect(32'h100);
        run(20);
        check("t3_next_req", qat(grants, 5), 32'h100);
        begin
            logic [31:0] exp3 [6];
            exp3 = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h104};
            for (int unsigned i = 0; i < 6; i++) begin
                check("t3_pop_pc", qat(pops, i), exp3[i]);
            end
        end

        // Redirect in REQ with grant withheld: old address held, then 0x200
        do_reset(1'b0);
        wait_grant(32'h8);
        gnt_en = 1'b0;
        tick();
        tick();
        check("t4_req",  32'(bus.imem_req_o), 32'd1);
        check("t4_addr", bus.imem_addr_o,     32'hC);
        redirect(32'h200);
        check("t4_hold1", bus.imem_addr_o, 32'hC);
        tick();
        check("t4_hold2", bus.imem_addr_o, 32'hC);
        gnt_en = 1'b1;
        tick();
        check("t4_hold3", bus.imem_addr_o, 32'hC);
        run(12);
        check("t4_stale_grant", qat(grants, 3), 32'hC);
        check("t4_new_req",     qat(grants, 4), 32'h200);
        check("t4_pop0", qat(pops, 0), 32'h0);
        check("t4_pop1", qat(pops, 1), 32'h4);
        check("t4_pop2", qat(pops, 2), 32'h200);

        // Redirect and pop together with a full buffer
        do_reset(1'b0);
        bus.inst_ready_i = 1'b0;
        run(10);
        check("t5_full_valid", 32'(bus.inst_valid_o), 32'd1);
        bus.inst_ready_i = 1'b1;
        redirect(32'h300);
        check("t5_flushed", 32'(bus.inst_valid_o), 32'd0);
        pops.delete();
        run(8);
        check("t5_first_pop", qat(pops, 0), 32'h300);

        // Misaligned redirect target
        do_reset(1'b0);
        redirect(32'h102);
`ifdef IF_MISALIGN_CHK_EN
        check("t6_err", 32'(fetch_err_o), 32'd1);
        run(10);
        check("t6_no_req",   32'(bus.imem_req_o), 32'd0);
        check("t6_ngrants",  32'(grants.size()),  32'd0);
        check("t6_err_hold", 32'(fetch_err_o),    32'd1);
        do_reset(1'b0);
        check("t6_err_clr", 32'(fetch_err_o), 32'd0);
        run(4);
        check("t6_restart", qat(grants, 0), 32'h0);
`else
        run(8);
        check("t6_aligned_req", qat(grants, 0), 32'h100);
        check("t6_aligned_pop", qat(pops, 0),   32'h100);
`endif

        // PC wrap at the top of the address space
        do_reset(1'b0);
        redirect(32'hFFFF_FFFC);
        run(8);
        check("t7_top",  qat(grants, 0), 32'hFFFF_FFFC);
        check("t7_wrap", qat(grants, 1), 32'h0);
        check("t7_pop",  qat(pops, 0),   32'hFFFF_FFFC);

        // Reset pulse mid-transaction; the late rvalid is ignored
        do_reset(1'b0);
        wait_grant(32'h4);
        tick();
        rstn = 1'b0;
        #1;
        check("t8_rst_req",   32'(bus.imem_req_o),   32'd0);
        check("t8_rst_valid", 32'(bus.inst_valid_o), 32'd0);
        rstn = 1'b1;
        grants.delete();
        pops.delete();
        insts.delete();
        tick();
        check("t8_late_rvalid", 32'(bus.inst_valid_o), 32'd0);
        run(6);
        check("t8_restart_pc", qat(pops, 0), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
